rv32i_inst_encoder: RTL and testbench

- Inverse of the RV32I instruction decoder: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, imm) into a 32-bit RV32I instruction word.
- Streaming block with valid/ready on both sides, a registered output stage and a one-entry skid buffer.
- Used by the instruction-memory preload path and as the golden source for decoder round-trip benches.

---
 rtl/rv32i_inst_encoder.sv | 159 +++++++++++++++
 tb/tb_rv32i_inst_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_inst_encoder
// Function : Packs decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7,
//            imm) into a 32-bit instruction word. Streaming valid/ready on
//            both sides, registered output stage plus a one-entry skid buffer.
//            Optional macro ENC_RANGE_CHECK_EN flags immediates that do not
//            fit the selected format (the truncated encoding is still output).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    logic [31:0]      w_enc_inst;
    logic             w_opc_err;
    logic             w_enc_err;
    logic             w_is_shift;
    logic             w_in_xfer;
    logic             w_out_free;

    logic             r_out_valid;
    logic [31:0]      r_inst;
    logic             r_err;
    logic             r_skid_valid;
    logic [31:0]      r_skid_inst;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_enc_count;

    // Shift-immediate instructions carry funct7 in the upper immediate bits.
    assign w_is_shift = (opcode == c_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Format selection and field packing; unknown opcodes encode as zero.
    always_comb begin
        w_enc_inst = 32'h0000_0000;
        w_opc_err  = 1'b0;
        case (opcode)
            c_OP_R: w_enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM: begin
                if (w_is_shift)
                    w_enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                else
                    w_enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
            end
            c_OP_STORE:  w_enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            c_OP_BRANCH: w_enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                                       imm[4:1], imm[11], opcode};
            c_OP_LUI, c_OP_AUIPC: w_enc_inst = {imm[31:12], rd, opcode};
            c_OP_JAL:    w_enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:     w_opc_err  = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_range_err;

    // Flags immediates that lose information when truncated into the format.
    always_comb begin
        w_range_err = 1'b0;
        case (opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM: begin
                if (w_is_shift)
                    w_range_err = |imm[31:5];
                else
                    w_range_err = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            c_OP_STORE:  w_range_err = (imm != {{20{imm[11]}}, imm[11:0]});
            c_OP_BRANCH: w_range_err = (imm != {{19{imm[12]}}, imm[12:0]}) | imm[0];
            c_OP_JAL:    w_range_err = (imm != {{11{imm[20]}}, imm[20:0]}) | imm[0];
            c_OP_LUI, c_OP_AUIPC: w_range_err = |imm[11:0];
            default:     w_range_err = 1'b0;
        endcase
    end

    assign w_enc_err = w_opc_err | w_range_err;
`else
    assign w_enc_err = w_opc_err;
`endif

    // in_ready is a pure register output: the skid entry is free.
    assign in_ready   = ~r_skid_valid;
    assign w_in_xfer  = in_valid & ~r_skid_valid;
    // The output register can take a new entry when empty or draining now.
    assign w_out_free = ~r_out_valid | out_ready;

    // Output stage and skid entry; skid drains first to keep FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_err        <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= 32'h0000_0000;
            r_skid_err   <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid full implies in_ready was low, so no new bundle here.
                r_out_valid  <= 1'b1;
                r_inst       <= r_skid_inst;
                r_err        <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_valid  <= 1'b1;
                r_inst       <= w_enc_inst;
                r_err        <= w_enc_err;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_in_xfer) begin
            // Output stalled: park the new bundle in the skid entry.
            r_skid_valid <= 1'b1;
            r_skid_inst  <= w_enc_inst;
            r_skid_err   <= w_enc_err;
        end
    end

    // Counts completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst)
            r_enc_count <= '0;
        else if (r_out_valid && out_ready)
            r_enc_count <= r_enc_count + CNT_W'(1);
    end

    assign out_valid = r_out_valid;
    assign inst      = r_inst;
    assign err       = r_err;
    assign enc_count = r_enc_count;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_inst_encoder
// Function : Self-checking bench for rv32i_inst_encoder: table of directed
//            encode vectors plus backpressure, wrap and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_inst_encoder;

    localparam int CNT_W = 4;
`ifdef ENC_RANGE_CHECK_EN
    localparam logic c_RC = 1'b1;
`else
    localparam logic c_RC = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst;
    logic             err;
    logic [CNT_W-1:0] enc_count;

    int n_total;
    int n_pass;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    vec_t vecs [18];

    rv32i_inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err),
        .enc_count (enc_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                                input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] iv, input logic [31:0] ei, input logic ee);
        vec_t v;
        v.op = op; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v; v.f3 = f3; v.f7 = f7;
        v.imm = iv; v.e_inst = ei; v.e_err = ee;
        return v;
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

        // Hand-computed encodings
        vecs[0]  = mk(7'b0000011, 5, 3, 0, 3'b010, 7'h00, 32'hFFFF_FFFC, 32'hFFC1A283, 1'b0); // lw x5,-4(x3)
        vecs[1]  = mk(7'b0100011, 0, 3, 5, 3'b010, 7'h00, 32'hFFFF_FFFC, 32'hFE51AE23, 1'b0); // sw x5,-4(x3)
        vecs[2]  = mk(7'b1100011, 0, 3, 5, 3'b100, 7'h00, 32'hFFFF_FFFC, 32'hFE51CEE3, 1'b0); // blt x3,x5,-4
        vecs[3]  = mk(7'b0110011, 1, 2, 3, 3'b000, 7'h00, 32'h0,         32'h003100B3, 1'b0); // add
        vecs[4]  = mk(7'b0110011, 1, 2, 3, 3'b000, 7'h20, 32'h0,         32'h403100B3, 1'b0); // sub
        vecs[5]  = mk(7'b0010011, 1, 2, 0, 3'b101, 7'h20, 32'h3,         32'h40315093, 1'b0); // srai x1,x2,3
        vecs[6]  = mk(7'b0010011, 1, 0, 31, 3'b000, 7'h7F, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0); // addi x1,x0,-1
        vecs[7]  = mk(7'b0110111, 5, 31, 31, 3'b111, 7'h7F, 32'h1234_5000, 32'h123452B7, 1'b0); // lui, junk fields
        vecs[8]  = mk(7'b0010111, 1, 0, 0, 3'b000, 7'h00, 32'hFFFF_F000, 32'hFFFFF097, 1'b0); // auipc
        vecs[9]  = mk(7'b1101111, 1, 0, 0, 3'b000, 7'h00, 32'h8,         32'h008000EF, 1'b0); // jal x1,8
        vecs[10] = mk(7'b1101111, 0, 0, 0, 3'b000, 7'h00, 32'hFFFF_FFFC, 32'hFFDFF06F, 1'b0); // jal x0,-4
        vecs[11] = mk(7'b1100011, 0, 0, 0, 3'b000, 7'h00, 32'h8,         32'h00000463, 1'b0); // beq x0,x0,8
        vecs[12] = mk(7'b1100111, 0, 1, 0, 3'b000, 7'h00, 32'h0,         32'h00008067, 1'b0); // jalr x0,0(x1)
        vecs[13] = mk(7'b1111111, 7, 7, 7, 3'b111, 7'h7F, 32'hFFFF_FFFF, 32'h00000000, 1'b1); // illegal
        vecs[14] = mk(7'b1100011, 0, 3, 5, 3'b100, 7'h00, 32'hFFFF_FFFD, 32'hFE51CEE3, c_RC); // blt odd
        vecs[15] = mk(7'b0010011, 1, 0, 0, 3'b000, 7'h00, 32'h0000_0800, 32'h80000093, c_RC); // addi 2048
        vecs[16] = mk(7'b0110111, 5, 0, 0, 3'b000, 7'h00, 32'h1234_5001, 32'h123452B7, c_RC); // lui low bits
        vecs[17] = mk(7'b0010011, 1, 2, 0, 3'b001, 7'h00, 32'h0000_0023, 32'h00311093, c_RC); // slli big shamt

        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_enc_count", {{(32-CNT_W){1'b0}}, enc_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Streaming table: one bundle per cycle, output drains while next loads
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {31'b0, out_valid}, 32'd0);
        chk("stream_count", {{(32-CNT_W){1'b0}}, enc_count}, 32'd18 % (1 << CNT_W));

        // Backpressure: lw then sw with output stalled
        do_reset();
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        step();
        chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_first_inst", inst, 32'hFFC1A283);
        chk("bp_ready_after_first", {31'b0, in_ready}, 32'd1);
        drive(vecs[1]);
        step();
        in_valid = 1'b0;
        chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_inst", inst, 32'hFFC1A283);
        step();
        chk("bp_hold_inst2", inst, 32'hFFC1A283);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_second_inst", inst, 32'hFE51AE23);
        chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);
        chk("bp_count", {{(32-CNT_W){1'b0}}, enc_count}, 32'd2);

        // Counter wrap with illegal-opcode transfers
        do_reset();
        out_ready = 1'b1;
        drive(vecs[13]);
        in_valid = 1'b1;
        repeat (17) step();
        in_valid = 1'b0;
        step();
        chk("wrap_count", {{(32-CNT_W){1'b0}}, enc_count}, 32'd17 % (1 << CNT_W));

        // Reset while output and skid are both full, with handshakes pending
        out_ready = 1'b0;
        drive(vecs[3]);
        in_valid = 1'b1;
        step();
        drive(vecs[4]);
        step();
        chk("full_ready_low", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(vecs[5]);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("frst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("frst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("frst_count", {{(32-CNT_W){1'b0}}, enc_count}, 32'd0);
        chk("frst_inst", inst, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("frst_no_stale%0d", k), {31'b0, out_valid}, 32'd0);
        end
        chk("frst_count_after", {{(32-CNT_W){1'b0}}, enc_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
